// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector between ID and EX: requests a one-stall bubble when a load
// in EX writes a register read by the ID instruction, and latches a sticky hazard LED.
module hazard_detection_unit #(
    parameter int CANT_BITS_ADDR_REGISTROS = 5
) (
    input  logic                                i_clock,
    input  logic                                i_reset,
    input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rs_id,
    input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rt_id,
    input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_registro_destino_ex,
    input  logic                                i_read_mem_ex,
    input  logic                                i_disable_for_exception,
    output logic                                o_bit_burbuja,
    output logic                                o_led
);

    logic w_match_rs;
    logic w_match_rt;
    logic w_hazard;
    logic w_burbuja;
    logic r_led;

    // Register $0 is deliberately not special-cased: a load targeting it still stalls.
    assign w_match_rs = (i_registro_destino_ex == i_rs_id);
    assign w_match_rt = (i_registro_destino_ex == i_rt_id);
    assign w_hazard   = i_read_mem_ex & (w_match_rs | w_match_rt);
    assign w_burbuja  = w_hazard & ~i_disable_for_exception;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_led <= 1'b0;
        end else if (w_burbuja) begin
            r_led <= 1'b1;
        end
    end

    assign o_bit_burbuja = w_burbuja;
    assign o_led         = r_led;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench: stimulus pushes hand-computed expectations into a queue and a
// separate monitor pops each entry and compares it against the live DUT outputs.
module tb_hazard_detection_unit;

    localparam int W = 5;

    logic         clk;
    logic         rst;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] dest;
    logic         rd_mem;
    logic         dis;
    logic         bub;
    logic         led;

    typedef struct {
        string name;
        logic  exp_bub;
        logic  exp_led;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    hazard_detection_unit #(.CANT_BITS_ADDR_REGISTROS(W)) dut (
        .i_clock                 (clk),
        .i_reset                 (rst),
        .i_rs_id                 (rs),
        .i_rt_id                 (rt),
        .i_registro_destino_ex   (dest),
        .i_read_mem_ex           (rd_mem),
        .i_disable_for_exception (dis),
        .o_bit_burbuja           (bub),
        .o_led                   (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: samples the DUT in the same time step the expectation is posted.
    initial begin
        exp_t e;
        forever begin
            wait (exp_q.size() != 0);
            e = exp_q.pop_front();
            n_checks++;
            if (bub !== e.exp_bub) begin
                n_errors++;
                $display("FAIL %s.bubble: got %b expected %b", e.name, bub, e.exp_bub);
            end
            n_checks++;
            if (led !== e.exp_led) begin
                n_errors++;
                $display("FAIL %s.led: got %b expected %b", e.name, led, e.exp_led);
            end
            $display("check %-16s bubble=%b(exp %b) led=%b(exp %b)",
                     e.name, bub, e.exp_bub, led, e.exp_led);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Drive new inputs just after a falling edge, then post the expectation 1 time unit later.
    task automatic drive(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] d, input logic m, input logic x,
                         input string name, input logic eb, input logic el);
        exp_t e;
        @(negedge clk);
        rst = r; rs = a; rt = b; dest = d; rd_mem = m; dis = x;
        #1;
        e.name = name; e.exp_bub = eb; e.exp_led = el;
        exp_q.push_back(e);
    endtask

    // Let one rising edge pass with inputs unchanged, then post the expectation.
    task automatic tick(input string name, input logic eb, input logic el);
        exp_t e;
        @(posedge clk);
        #1;
        e.name = name; e.exp_bub = eb; e.exp_led = el;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; rs = 5'd1; rt = 5'd2; dest = 5'd0; rd_mem = 1'b0; dis = 1'b0;
        repeat (2) @(posedge clk);
        tick("reset_state", 1'b0, 1'b0);

        drive(0, 5'd1, 5'd2, 5'd0, 0, 0, "idle", 1'b0, 1'b0);
        tick("idle_edge", 1'b0, 1'b0);

        drive(0, 5'd1, 5'd2, 5'd1, 0, 0, "no_load", 1'b0, 1'b0);
        drive(0, 5'd1, 5'd2, 5'd1, 1, 0, "rs_match_comb", 1'b1, 1'b0);
        tick("led_set", 1'b1, 1'b1);

        drive(0, 5'd1, 5'd2, 5'd1, 1, 1, "disable_prio", 1'b0, 1'b1);
        drive(0, 5'd1, 5'd2, 5'd1, 1, 0, "disable_release", 1'b1, 1'b1);

        drive(0, 5'd1, 5'd2, 5'd2, 1, 0, "rt_match", 1'b1, 1'b1);
        drive(0, 5'd1, 5'd2, 5'd3, 1, 0, "no_match", 1'b0, 1'b1);
        tick("led_sticky", 1'b0, 1'b1);
        drive(0, 5'h11, 5'd2, 5'd1, 1, 0, "full_width_cmp", 1'b0, 1'b1);

        drive(1, 5'd1, 5'd2, 5'd1, 1, 0, "reset_pre_edge", 1'b1, 1'b1);
        tick("reset_over_hzd", 1'b1, 1'b0);
        drive(0, 5'd1, 5'd2, 5'd1, 1, 0, "reset_release", 1'b1, 1'b0);
        tick("led_reset_rise", 1'b1, 1'b1);

        drive(1, 5'd1, 5'd2, 5'd1, 0, 0, "fresh_reset", 1'b0, 1'b1);
        tick("fresh_reset_edge", 1'b0, 1'b0);
        drive(0, 5'd1, 5'd2, 5'd1, 1, 1, "suppressed", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick("suppr_no_led", 1'b0, 1'b0);

        drive(0, 5'd0, 5'd0, 5'd0, 1, 0, "reg0_hazard", 1'b1, 1'b0);
        tick("reg0_led", 1'b1, 1'b1);

        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
